// File: rtl/bm_divmod_seq_arch.sv
// Sequential unsigned restoring divider: one quotient bit per clock,
// start/busy/done handshake, registered quotient/remainder/div_by_zero results.
module bm_divmod_seq_arch #(
    parameter int BITS0 = 9,
    parameter int BITS2 = 18
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [BITS2-1:0] dividend,
    input  logic [BITS0-1:0] divisor,
    output logic [BITS2-1:0] quotient,
    output logic [BITS0-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(BITS2);

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_CALC
    } state_e;

    state_e           state_q, state_d;
    logic [BITS0-1:0] r_q, r_d;
    logic [BITS2-1:0] q_q, q_d;
    logic [BITS0-1:0] dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BITS2-1:0] quotient_q, quotient_d;
    logic [BITS0-1:0] remainder_q, remainder_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;
    logic [BITS0:0]   t;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        q_d         = q_q;
        dvs_d       = dvs_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        done_d      = 1'b0;
        t           = '0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (divisor != '0) begin
                        dvs_d   = divisor;
                        r_d     = '0;
                        q_d     = dividend;
                        cnt_d   = CNT_W'(BITS2 - 1);
                        state_d = ST_CALC;
                    end else begin
                        quotient_d  = '1;
                        remainder_d = dividend[BITS0-1:0];
                        dbz_d       = 1'b1;
                        done_d      = 1'b1;
                    end
                end
            end
            ST_CALC: begin
                // The partial remainder only needs its extra bit inside t; after a
                // restore or subtract it is always below the divisor again.
                t   = {r_q, q_q[BITS2-1]};
                q_d = {q_q[BITS2-2:0], 1'b0};
                if (t >= {1'b0, dvs_q}) begin
                    r_d    = BITS0'(t - {1'b0, dvs_q});
                    q_d[0] = 1'b1;
                end else begin
                    r_d = t[BITS0-1:0];
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    quotient_d  = q_d;
                    remainder_d = r_d;
                    dbz_d       = 1'b0;
                    done_d      = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            r_q         <= '0;
            q_q         <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            q_q         <= q_d;
            dvs_q       <= dvs_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            done_q      <= done_d;
            dbz_q       <= dbz_d;
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign busy        = (state_q == ST_CALC);
    assign done        = done_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_bm_divmod_seq_arch.sv
// Scoreboard bench for bm_divmod_seq_arch: stimulus pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_bm_divmod_seq_arch;

    localparam int BITS0 = 9;
    localparam int BITS2 = 18;

    logic             clock;
    logic             reset_n;
    logic             start;
    logic [BITS2-1:0] dividend;
    logic [BITS0-1:0] divisor;
    logic [BITS2-1:0] quotient;
    logic [BITS0-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    typedef struct {
        logic [BITS2-1:0] q;
        logic [BITS0-1:0] r;
        logic             dbz;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    bm_divmod_seq_arch #(.BITS0(BITS0), .BITS2(BITS2)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (reset_n && done) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_done: got done=1 with no outstanding op, expected done=0");
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("quotient", 32'(quotient), 32'(e.q));
                check("remainder", 32'(remainder), 32'(e.r));
                check("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
                check("busy_in_done", 32'(busy), 32'd0);
            end
        end
    end

    // Issue one op from IDLE and measure edges from the accepting edge to done.
    // A nonzero intr_at pulses a competing 50/5 request that many edges after acceptance.
    task automatic run_op(input logic [BITS2-1:0] dvd, input logic [BITS0-1:0] dvs,
                          input logic [BITS2-1:0] eq, input logic [BITS0-1:0] er,
                          input logic edbz, input int exp_lat, input int intr_at);
        int lat;
        exp_t e;
        @(posedge clock); #1;
        start = 1'b1; dividend = dvd; divisor = dvs;
        e.q = eq; e.r = er; e.dbz = edbz;
        sb.push_back(e);
        @(posedge clock); #1;
        start = 1'b0;
        lat = 0;
        if (exp_lat > 0) check("busy_after_accept", 32'(busy), 32'd1);
        while (!done && lat < 40) begin
            @(posedge clock); #1;
            lat++;
            if (intr_at != 0 && lat == intr_at) begin
                start = 1'b1; dividend = 18'd50; divisor = 9'd5;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check("latency", 32'(lat), 32'(exp_lat));
    endtask

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        start = 1'b0; dividend = '0; divisor = '0;
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("reset_quotient", 32'(quotient), 32'd0);
        check("reset_remainder", 32'(remainder), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_dbz", 32'(div_by_zero), 32'd0);
        reset_n = 1'b1;

        // Basic division and boundary cases.
        run_op(18'd1000, 9'd7, 18'd142, 9'd6, 1'b0, 18, 0);
        run_op(18'd262143, 9'd1, 18'd262143, 9'd0, 1'b0, 18, 0);
        run_op(18'd5, 9'd9, 18'd0, 9'd5, 1'b0, 18, 0);
        run_op(18'd0, 9'd5, 18'd0, 9'd0, 1'b0, 18, 0);
        run_op(18'd262143, 9'd511, 18'd513, 9'd0, 1'b0, 18, 0);

        // Divide by zero: remainder is the low BITS0 bits of the dividend.
        run_op(18'd300, 9'd0, 18'h3FFFF, 9'd300, 1'b1, 0, 0);
        run_op(18'd77, 9'd8, 18'd9, 9'd5, 1'b0, 18, 0);

        // Start while busy is ignored; results hold afterwards.
        run_op(18'd1000, 9'd7, 18'd142, 9'd6, 1'b0, 18, 5);
        repeat (3) @(posedge clock);
        #1;
        check("hold_quotient", 32'(quotient), 32'd142);
        check("hold_remainder", 32'(remainder), 32'd6);
        check("hold_done_low", 32'(done), 32'd0);

        // Reset mid-calculation aborts the op with no done.
        @(posedge clock); #1;
        start = 1'b1; dividend = 18'd1000; divisor = 9'd7;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (8) @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        check("abort_quotient", 32'(quotient), 32'd0);
        check("abort_remainder", 32'(remainder), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_dbz", 32'(div_by_zero), 32'd0);
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        repeat (25) @(posedge clock);
        #1;
        check("abort_idle", 32'(busy), 32'd0);
        run_op(18'd77, 9'd8, 18'd9, 9'd5, 1'b0, 18, 0);

        // Back-to-back random ops: the next start is presented in each done cycle.
        @(posedge clock); #1;
        for (int i = 0; i < 1000; i++) begin
            int c, a, b, w;
            exp_t e;
            c = $urandom_range(1, 511);
            a = $urandom_range(0, 511);
            b = $urandom_range(0, c - 1);
            start = 1'b1;
            dividend = BITS2'(c * a + b);
            divisor = BITS0'(c);
            e.q = BITS2'(a); e.r = BITS0'(b); e.dbz = 1'b0;
            sb.push_back(e);
            @(posedge clock); #1;
            w = 0;
            while (!done && w < 40) begin
                @(posedge clock); #1;
                w++;
            end
            if (w >= 40) begin
                n_checks++;
                n_errors++;
                $display("FAIL rand_timeout: got no done after %0d edges, expected done", w);
                break;
            end
        end
        start = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
